// File: rtl/step_mon_pkg.sv
// Shared types and default widths for the step counter monitor.
// Pulled in by step_wrap_detector and step_count_monitor.
package step_mon_pkg;

  localparam int unsigned WIDTH_D   = 4;
  localparam int unsigned WRAP_W_D  = 8;
  localparam int unsigned TIMEOUT_D = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_t;

endpackage

// File: rtl/step_wrap_detector.sv
// Tracks the previous count sample and reports step size and wraps.
// Also keeps a saturating wrap total.
module step_wrap_detector
  import step_mon_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_D,
  parameter int unsigned WRAP_W = WRAP_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  i_count,
  input  logic              i_load,
  input  logic              i_count_en,
  output logic [WIDTH-1:0]  o_step,
  output logic              o_wrap_pulse,
  output logic [WRAP_W-1:0] o_wrap_total,
  output logic [WRAP_W-1:0] o_total_nxt,
  output logic              o_prev_valid
);

  logic [WIDTH-1:0]  r_prev;
  logic              r_prev_valid;
  logic              r_load_q;
  logic [WIDTH-1:0]  r_step;
  logic              r_wrap_pulse;
  logic [WRAP_W-1:0] r_total;

  logic              w_step_ok;
  logic              w_wrap;
  logic [WRAP_W-1:0] w_total_nxt;

  // A loaded value is never a step, whether the load is seen now or last cycle.
  assign w_step_ok = r_prev_valid & i_count_en & ~i_load & ~r_load_q;
  assign w_wrap    = w_step_ok & (i_count < r_prev);

  assign w_total_nxt = (w_wrap && (r_total != '1))
                     ? r_total + WRAP_W'(1)
                     : r_total;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_load_q     <= 1'b0;
      r_step       <= '0;
      r_wrap_pulse <= 1'b0;
      r_total      <= '0;
    end else begin
      r_prev       <= i_count;
      r_prev_valid <= 1'b1;
      r_load_q     <= i_load;
      r_wrap_pulse <= w_wrap;
      r_total      <= w_total_nxt;
      if (w_step_ok) begin
        r_step <= i_count - r_prev;
      end
    end
  end

  assign o_step       = r_step;
  assign o_wrap_pulse = r_wrap_pulse;
  assign o_wrap_total = r_total;
  assign o_total_nxt  = w_total_nxt;
  assign o_prev_valid = r_prev_valid;

endmodule

// File: rtl/step_count_monitor.sv
// Step counter observer: wrap/step reporting plus armed target match.
// Optional ARMED timeout enabled by defining STEP_MON_TIMEOUT_EN.
module step_count_monitor
  import step_mon_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_D,
  parameter int unsigned WRAP_W  = WRAP_W_D,
  parameter int unsigned TIMEOUT = TIMEOUT_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              load_in,
  input  logic              count_en_in,
  input  logic [WIDTH-1:0]  target,
  input  logic              arm,
  input  logic              ack,
  output logic [WIDTH-1:0]  step_out,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_total,
  output logic              req,
  output logic [WRAP_W-1:0] hit_wraps,
  output logic              busy,
  output logic              timeout_pulse
);

  state_t            r_state;
  logic [WIDTH-1:0]  r_target_q;
  logic              r_req;
  logic [WRAP_W-1:0] r_hit_wraps;

  logic [WRAP_W-1:0] w_total_nxt;
  logic              w_prev_valid;
  logic              w_match;

  step_wrap_detector #(
    .WIDTH  (WIDTH),
    .WRAP_W (WRAP_W)
  ) u_det (
    .clk          (clk),
    .reset        (reset),
    .i_count      (count_in),
    .i_load       (load_in),
    .i_count_en   (count_en_in),
    .o_step       (step_out),
    .o_wrap_pulse (wrap_pulse),
    .o_wrap_total (wrap_total),
    .o_total_nxt  (w_total_nxt),
    .o_prev_valid (w_prev_valid)
  );

  assign w_match = w_prev_valid & (count_in == r_target_q);

`ifdef STEP_MON_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_tpulse;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_target_q  <= '0;
      r_req       <= 1'b0;
      r_hit_wraps <= '0;
`ifdef STEP_MON_TIMEOUT_EN
      r_tcnt      <= '0;
      r_tpulse    <= 1'b0;
`endif
    end else begin
`ifdef STEP_MON_TIMEOUT_EN
      r_tpulse <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (arm) begin
            r_state    <= ARMED;
            r_target_q <= target;
`ifdef STEP_MON_TIMEOUT_EN
            r_tcnt     <= '0;
`endif
          end
        end
        ARMED: begin
          // Re-arm wins over a match seen in the same cycle.
          if (arm) begin
            r_target_q <= target;
`ifdef STEP_MON_TIMEOUT_EN
            r_tcnt     <= '0;
`endif
          end else if (w_match) begin
            r_state     <= HIT;
            r_req       <= 1'b1;
            r_hit_wraps <= w_total_nxt;
`ifdef STEP_MON_TIMEOUT_EN
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_state  <= IDLE;
            r_tpulse <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
`endif
          end
        end
        HIT: begin
          if (ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req       = r_req;
  assign hit_wraps = r_hit_wraps;
  assign busy      = (r_state != IDLE);

`ifdef STEP_MON_TIMEOUT_EN
  assign timeout_pulse = r_tpulse;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_step_count_monitor.sv
// Self-checking bench for step_count_monitor (WRAP_W=8 and WRAP_W=2 copies).
// Both copies share stimulus; expectations come from a behavioural model.
module tb_step_count_monitor;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic [3:0] target;
  logic       load_in;
  logic       count_en_in;
  logic       arm;
  logic       ack;

  logic [3:0] step_a, step_b;
  logic       wp_a, wp_b;
  logic [7:0] wt_a, hw_a;
  logic [1:0] wt_b, hw_b;
  logic       req_a, req_b;
  logic       busy_a, busy_b;
  logic       to_a, to_b;

  int n_run  = 0;
  int n_fail = 0;

  // behavioural model state
  int m_pc, m_pv, m_lq;
  int m_step, m_pulse;
  int m_tot8, m_tot2, m_hw8, m_hw2;
  int m_st, m_tq, m_req, m_wait, m_tp;

  always #5 clk = ~clk;

  step_count_monitor #(
    .WIDTH   (4),
    .WRAP_W  (8),
    .TIMEOUT (TO)
  ) u_dut (
    .clk           (clk),
    .reset         (rst),
    .count_in      (count_in),
    .load_in       (load_in),
    .count_en_in   (count_en_in),
    .target        (target),
    .arm           (arm),
    .ack           (ack),
    .step_out      (step_a),
    .wrap_pulse    (wp_a),
    .wrap_total    (wt_a),
    .req           (req_a),
    .hit_wraps     (hw_a),
    .busy          (busy_a),
    .timeout_pulse (to_a)
  );

  step_count_monitor #(
    .WIDTH   (4),
    .WRAP_W  (2),
    .TIMEOUT (TO)
  ) u_sat (
    .clk           (clk),
    .reset         (rst),
    .count_in      (count_in),
    .load_in       (load_in),
    .count_en_in   (count_en_in),
    .target        (target),
    .arm           (arm),
    .ack           (ack),
    .step_out      (step_b),
    .wrap_pulse    (wp_b),
    .wrap_total    (wt_b),
    .req           (req_b),
    .hit_wraps     (hw_b),
    .busy          (busy_b),
    .timeout_pulse (to_b)
  );

  task automatic m_reset();
    m_pc = 0; m_pv = 0; m_lq = 0;
    m_step = 0; m_pulse = 0;
    m_tot8 = 0; m_tot2 = 0; m_hw8 = 0; m_hw2 = 0;
    m_st = 0; m_tq = 0; m_req = 0; m_wait = 0; m_tp = 0;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT samples.
  task automatic tick();
    int stepping, wrapped, n8, n2, c;
    c = int'(count_in);
    stepping = (m_pv != 0) && count_en_in && !load_in && (m_lq == 0);
    wrapped  = stepping && (c < m_pc);
    if (stepping) m_step = (c - m_pc + 16) % 16;
    m_pulse = wrapped;
    n8 = wrapped ? ((m_tot8 + 1 > 255) ? 255 : m_tot8 + 1) : m_tot8;
    n2 = wrapped ? ((m_tot2 + 1 > 3) ? 3 : m_tot2 + 1) : m_tot2;
    m_tp = 0;
    if (m_st == 0) begin
      if (arm) begin m_st = 1; m_tq = int'(target); m_wait = 0; end
    end else if (m_st == 1) begin
      if (arm) begin
        m_tq = int'(target); m_wait = 0;
      end else if (m_pv != 0 && c == m_tq) begin
        m_st = 2; m_req = 1; m_hw8 = n8; m_hw2 = n2;
      end else begin
        m_wait++;
`ifdef STEP_MON_TIMEOUT_EN
        if (m_wait == TO) begin m_st = 0; m_tp = 1; end
`endif
      end
    end else begin
      if (ack) begin m_st = 0; m_req = 0; end
    end
    m_tot8 = n8; m_tot2 = n2;
    m_pc = c; m_pv = 1; m_lq = int'(load_in);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    count_in = 4'd0; target = 4'd0;
    load_in = 1'b0; count_en_in = 1'b0;
    arm = 1'b0; ack = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({step_a, wp_a, wt_a, req_a, hw_a, busy_a, to_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_a: got %h want 0",
        {step_a, wp_a, wt_a, req_a, hw_a, busy_a, to_a});
    end
    n_run++;
    if ({step_b, wp_b, wt_b, req_b, hw_b, busy_b, to_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 0",
        {step_b, wp_b, wt_b, req_b, hw_b, busy_b, to_b});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_step_wrap();
    int seq [7] = '{0, 3, 6, 9, 12, 15, 2};
    count_en_in = 1'b1;
    foreach (seq[i]) begin
      count_in = 4'(seq[i]);
      tick();
      n_run++;
      if (wp_a !== 1'(m_pulse) || step_a !== 4'(m_step)) begin
        n_fail++;
        $display("FAIL step_seq[%0d]: got step=%0d wp=%0d want step=%0d wp=%0d",
          i, step_a, wp_a, m_step, m_pulse);
      end
    end
    n_run++;
    if (step_a !== 4'd3 || wp_a !== 1'b1 || wt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_first: got step=%0d wp=%0d tot=%0d want 3 1 1",
        step_a, wp_a, wt_a);
    end
    count_in = 4'd5;
    tick();
    n_run++;
    if (wp_a !== 1'b0 || wt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_one_cycle: got wp=%0d tot=%0d want 0 1", wp_a, wt_a);
    end
  endtask

  task automatic test_load();
    count_in = 4'd15; load_in = 1'b1;
    tick();
    count_in = 4'd9;
    tick();
    load_in = 1'b0; count_en_in = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      n_run++;
      if (wp_a !== 1'b0 || wt_a !== 8'd1 || wt_a !== 8'(m_tot8)) begin
        n_fail++;
        $display("FAIL load_no_wrap[%0d]: got wp=%0d tot=%0d want 0 1",
          i, wp_a, wt_a);
      end
    end
  endtask

  task automatic test_match();
    count_in = 4'd4; load_in = 1'b1; count_en_in = 1'b1;
    arm = 1'b1; target = 4'd9;
    tick();
    arm = 1'b0; load_in = 1'b0; target = 4'd0;
    n_run++;
    if (busy_a !== 1'b1 || req_a !== 1'b0) begin
      n_fail++;
      $display("FAIL armed: got busy=%0d req=%0d want 1 0", busy_a, req_a);
    end
    for (int v = 5; v <= 9; v++) begin
      count_in = 4'(v);
      tick();
      n_run++;
      if (req_a !== 1'(m_req) || req_a !== (v == 9)) begin
        n_fail++;
        $display("FAIL match_req[%0d]: got %0d want %0d", v, req_a, v == 9);
      end
    end
    n_run++;
    if (hw_a !== 8'd1 || hw_a !== 8'(m_hw8)) begin
      n_fail++;
      $display("FAIL hit_wraps: got %0d want 1", hw_a);
    end
    count_in = 4'd10;
    tick();
    count_in = 4'd11; ack = 1'b1;
    n_run++;
    if (req_a !== 1'b1) begin
      n_fail++;
      $display("FAIL req_hold: got %0d want 1", req_a);
    end
    tick();
    ack = 1'b0;
    n_run++;
    if (req_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_drop: got req=%0d busy=%0d want 0 0", req_a, busy_a);
    end
  endtask

  task automatic test_saturate();
    int c;
    bit got;
    c = int'(count_in);
    count_en_in = 1'b1;
    for (int i = 0; i < 24; i++) begin
      c = (c + 7) % 16;
      count_in = 4'(c);
      tick();
      n_run++;
      if (wt_b !== 2'(m_tot2) || wt_a !== 8'(m_tot8)) begin
        n_fail++;
        $display("FAIL sat_total[%0d]: got %0d/%0d want %0d/%0d",
          i, wt_a, wt_b, m_tot8, m_tot2);
      end
    end
    n_run++;
    if (wt_b !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_stick: got %0d want 3", wt_b);
    end
    arm = 1'b1; target = 4'd0;
    tick();
    arm = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      c = (c + 7) % 16;
      count_in = 4'(c);
      tick();
      got = req_a;
    end
    n_run++;
    if (!got || hw_b !== 2'd3 || hw_a !== 8'(m_hw8)) begin
      n_fail++;
      $display("FAIL sat_hit: got req=%0d hw=%0d/%0d want 1 %0d/3",
        got, hw_a, hw_b, m_hw8);
    end
    arm = 1'b1; target = 4'd5;
    tick();
    arm = 1'b0;
    n_run++;
    if (req_a !== 1'b1 || busy_a !== 1'b1 || m_st != 2) begin
      n_fail++;
      $display("FAIL arm_in_hit: got req=%0d busy=%0d want 1 1", req_a, busy_a);
    end
  endtask

  task automatic test_reset_mid_hit();
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    n_run++;
    if ({step_a, wp_a, wt_a, req_a, hw_a, busy_a, to_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL mid_hit_reset: got %h want 0",
        {step_a, wp_a, wt_a, req_a, hw_a, busy_a, to_a});
    end
    @(negedge clk);
    rst = 1'b1;
    count_in = 4'd7; count_en_in = 1'b1;
    tick();
    n_run++;
    if (wp_a !== 1'b0 || step_a !== 4'd0) begin
      n_fail++;
      $display("FAIL first_sample: got wp=%0d step=%0d want 0 0", wp_a, step_a);
    end
    count_in = 4'd2;
    tick();
    n_run++;
    if (wp_a !== 1'b1 || step_a !== 4'd11) begin
      n_fail++;
      $display("FAIL post_reset_wrap: got wp=%0d step=%0d want 1 11", wp_a, step_a);
    end
  endtask

`ifdef STEP_MON_TIMEOUT_EN
  task automatic test_timeout();
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    count_in = 4'd5; count_en_in = 1'b0;
    arm = 1'b1; target = 4'd1;
    tick();
    arm = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      tick();
      n_run++;
      if (to_a !== (i == TO) || to_a !== 1'(m_tp) || req_a !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got to=%0d req=%0d want %0d 0",
          i, to_a, req_a, i == TO);
      end
    end
    n_run++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got busy=%0d want 0", busy_a);
    end
    tick();
    n_run++;
    if (to_a !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse_len: got %0d want 0", to_a);
    end
  endtask
`else
  task automatic test_no_timeout();
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    count_in = 4'd5; count_en_in = 1'b0;
    arm = 1'b1; target = 4'd1;
    tick();
    arm = 1'b0;
    repeat (3 * TO) tick();
    n_run++;
    if (busy_a !== 1'b1 || to_a !== 1'b0 || req_a !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: got busy=%0d to=%0d req=%0d want 1 0 0",
        busy_a, to_a, req_a);
    end
    count_in = 4'd1;
    tick();
    n_run++;
    if (req_a !== 1'b1) begin
      n_fail++;
      $display("FAIL late_match: got %0d want 1", req_a);
    end
  endtask
`endif

  task automatic test_random();
    int c, stp;
    bit en, ld;
    c = int'(count_in);
    stp = 1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) stp = $urandom_range(1, 15);
      en = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 15) == 0);
      count_in    = 4'(c);
      count_en_in = en;
      load_in     = ld;
      arm    = ($urandom_range(0, 19) == 0);
      ack    = ($urandom_range(0, 3) == 0);
      target = 4'($urandom_range(0, 15));
      tick();
      if (ld) c = $urandom_range(0, 15);
      else if (en) c = (c + stp) % 16;
      n_run++;
      if (step_a !== 4'(m_step) || wp_a !== 1'(m_pulse) ||
          wt_a !== 8'(m_tot8)) begin
        n_fail++;
        $display("FAIL rnd_det[%0d]: got %0d %0d %0d want %0d %0d %0d",
          i, step_a, wp_a, wt_a, m_step, m_pulse, m_tot8);
      end
      n_run++;
      if (req_a !== 1'(m_req) || busy_a !== (m_st != 0) ||
          hw_a !== 8'(m_hw8) || to_a !== 1'(m_tp)) begin
        n_fail++;
        $display("FAIL rnd_fsm[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d",
          i, req_a, busy_a, hw_a, to_a, m_req, m_st != 0, m_hw8, m_tp);
      end
      n_run++;
      if (wt_b !== 2'(m_tot2) || hw_b !== 2'(m_hw2) ||
          req_b !== 1'(m_req)) begin
        n_fail++;
        $display("FAIL rnd_sat[%0d]: got %0d %0d %0d want %0d %0d %0d",
          i, wt_b, hw_b, req_b, m_tot2, m_hw2, m_req);
      end
    end
    arm = 1'b0; ack = 1'b0; load_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step_wrap();
    test_load();
    test_match();
    test_saturate();
    test_reset_mid_hit();
`ifdef STEP_MON_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/step_count_monitor.md
Name: step_count_monitor

Overview:
- Downstream observer of the 4-bit step counter; samples its `count` output every clock.
- Detects wrap-around, reports the observed step size, and counts wraps (saturating).
- Provides an armed match detector against a programmable target value, with a req/ack handshake to the consuming logic (display/controller).

Parameters:
- WIDTH, 4, width of the sampled count.
- WRAP_W, 8, width of the wrap total counter; saturates at 2^WRAP_W-1.
- TIMEOUT, 32, ARMED-state cycle limit; used only when STEP_MON_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- count_in  in  WIDTH  counter output.
- load_in  in  1  mirror of the counter's load; high means the next count change is a load, not a step.
- count_en_in  in  1  mirror of the counter enable.
- target  in  WIDTH  match value; sampled on arm.
- arm  in  1  single-cycle request to start match search.
- ack  in  1  consumer acknowledge of req.
- step_out  out  WIDTH  last observed delta, (count_in - prev) mod 2^WIDTH.
- wrap_pulse  out  1  one-cycle wrap indication.
- wrap_total  out  WRAP_W  saturating wrap count.
- req  out  1  match found, held until ack.
- hit_wraps  out  WRAP_W  wrap_total snapshot taken at match.
- busy  out  1  high in ARMED or HIT.
- timeout_pulse  out  1  one-cycle timeout indication; tied 0 when the macro is absent.

Behaviour:
- Reset (reset=0, asynchronous) clears all state:
  - Outputs: step_out, wrap_pulse, wrap_total, req, hit_wraps, busy, timeout_pulse all 0.
  - Internal: prev_count=0, prev_valid=0, state=IDLE, target_q=0.
- Every cycle: prev_count<=count_in and prev_valid<=1. The first sample after reset produces no wrap and no step.
- Step: step_out<=count_in-prev_count (mod 2^WIDTH) when prev_valid && count_en_in && !load_in; otherwise step_out holds.
- Wrap: wrap_pulse<=1 for one cycle when prev_valid && count_en_in && !load_in && count_in<prev_count (unsigned). Latency is 1 cycle after the sample that shows the wrap.
- wrap_total increments on each wrap and saturates at its maximum.
- A load producing a decrease (load_in=1 in the prior cycle, i.e. registered load_q) is never a wrap.
- FSM states are IDLE, ARMED and HIT. busy=1 in ARMED and HIT.
- IDLE:
  - arm=1 -> ARMED; target_q<=target.
  - A match in the same cycle as arm is not evaluated; evaluation starts the next cycle.
- ARMED:
  - Leaves for HIT when prev_valid && count_in==target_q.
  - On that transition: req<=1 and hit_wraps<=wrap_total, including any wrap detected in the same cycle.
  - arm while ARMED re-samples target and stays ARMED.
- HIT:
  - req stays high until ack=1; then req<=0 and the FSM goes to IDLE.
  - arm is ignored in HIT.
  - ack in IDLE or ARMED is ignored.
- Reset mid-HIT drops req immediately (asynchronous).
- wrap_total is never cleared except by reset.

Optional Feature:
- Macro: STEP_MON_TIMEOUT_EN.
- Defined:
  - A cycle counter (clog2(TIMEOUT+1) bits) clears on entry to ARMED.
  - After TIMEOUT cycles in ARMED without a match, the FSM goes to IDLE and timeout_pulse=1 for one cycle.
  - If a match occurs on the timeout cycle, the match wins.
- Absent: the FSM stays ARMED indefinitely and timeout_pulse is constant 0.

Decomposition:
- Package step_mon_pkg holds:
  - state enum (IDLE=2'd0, ARMED=2'd1, HIT=2'd2);
  - default width constants.
- One sub-module, step_wrap_detector, contains prev_count, load_q, step_out, wrap_pulse and the saturating wrap_total.
- The top holds the FSM, handshake and timeout.

Test Plan:
1. Reset, then count_en=1 with counter +3 from 0 (0,3,6,9,12,15,2) -> step_out=3; wrap_pulse one cycle after 2 is sampled; wrap_total=1.
2. Count=15, load_in=1 with data 9 -> count 9, no wrap_pulse, wrap_total unchanged.
3. arm with target=9, counter +1 from 4:
   - req rises the cycle after count_in=9 is sampled, and hit_wraps=wrap_total;
   - ack two cycles later drops req, FSM returns to IDLE, busy=0.
4. Force WRAP_W=2 and run 5 wraps -> wrap_total sticks at 3; arm while in HIT -> ignored.
5. Assert reset mid-HIT -> req and all outputs 0 immediately; the first sample after release produces no wrap.
6. With STEP_MON_TIMEOUT_EN and TIMEOUT=8, arm target=1 while counter holds at 5 -> timeout_pulse after 8 cycles, then IDLE, req never set.
